// File: rtl/fsm_watchdog_pkg.sv
// Shared types for the FSM watchdog monitor: per-channel monitor states,
// fault cause encoding and a helper for the channel-index width.
package fsm_watchdog_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        TIMEOUT  = 2'd2,
        ILLEGAL  = 2'd3
    } chan_state_e;

    typedef enum logic {
        CAUSE_TIMEOUT = 1'b0,
        CAUSE_ILLEGAL = 1'b1
    } cause_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/fsm_watchdog_chan.sv
// One monitored channel: tracks the observed FSM state, counts stalled
// cycles and latches a sticky timeout or illegal-encoding fault.
module fsm_watchdog_chan
    import fsm_watchdog_pkg::*;
#(
    parameter int STATE_W    = 3,
    parameter int NUM_STATES = 6,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic [CNT_W-1:0]   i_timeout_val,
    input  logic [STATE_W-1:0] i_state,
    output logic               o_timeout_flag,
    output logic               o_illegal_flag,
    output logic               o_trip,
    output cause_e             o_trip_cause
);

    // One extra bit so NUM_STATES == 2**STATE_W still compares correctly.
    localparam logic [STATE_W:0] LP_NUM_STATES = (STATE_W + 1)'(NUM_STATES);

    chan_state_e        r_state;
    chan_state_e        w_state_nxt;
    logic [STATE_W-1:0] r_state_q;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_illegal;
    logic               w_timeout;
    logic [CNT_W-1:0]   w_limit_m1;

    assign w_limit_m1 = i_timeout_val - CNT_W'(1);
    assign w_illegal  = ({1'b0, i_state} >= LP_NUM_STATES);
    // Equality compare: a counter already past a newly lowered limit never
    // matches until a state change restarts the count.
    assign w_timeout  = (i_timeout_val != '0) && (i_state == r_state_q) &&
                        (r_stall_cnt == w_limit_m1);

    // Monitor state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DISABLED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: disable beats clear, clear beats any trip, illegal beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DISABLED: begin
                if (i_enable) begin
                    w_state_nxt = ARMED;
                end else begin
                    w_state_nxt = DISABLED;
                end
            end
            ARMED: begin
                if (!i_enable) begin
                    w_state_nxt = DISABLED;
                end else if (i_clear) begin
                    w_state_nxt = ARMED;
                end else if (w_illegal) begin
                    w_state_nxt = ILLEGAL;
                end else if (w_timeout) begin
                    w_state_nxt = TIMEOUT;
                end else begin
                    w_state_nxt = ARMED;
                end
            end
            TIMEOUT, ILLEGAL: begin
                if (!i_enable) begin
                    w_state_nxt = DISABLED;
                end else if (i_clear) begin
                    w_state_nxt = ARMED;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = DISABLED;
            end
        endcase
    end

    // Observed-state copy and stall counter; both freeze while a fault is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= '0;
            r_stall_cnt <= '0;
        end else if (!i_enable) begin
            r_state_q   <= r_state_q;
            r_stall_cnt <= '0;
        end else if ((r_state == DISABLED) || i_clear) begin
            r_state_q   <= i_state;
            r_stall_cnt <= '0;
        end else if (r_state == ARMED) begin
            r_state_q <= i_state;
            if (i_state != r_state_q) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end else begin
            r_state_q   <= r_state_q;
            r_stall_cnt <= r_stall_cnt;
        end
    end

    // Output decode: flags come from the state register only; trip is the
    // ARMED-to-fault transition, used by the top for first-fault capture.
    always_comb begin
        o_timeout_flag = (r_state == TIMEOUT);
        o_illegal_flag = (r_state == ILLEGAL);
        o_trip         = (r_state == ARMED) &&
                         ((w_state_nxt == TIMEOUT) || (w_state_nxt == ILLEGAL));
        if (w_state_nxt == ILLEGAL) begin
            o_trip_cause = CAUSE_ILLEGAL;
        end else begin
            o_trip_cause = CAUSE_TIMEOUT;
        end
    end

endmodule

// File: rtl/fsm_watchdog_monitor.sv
// Multi-channel FSM watchdog: one monitor per channel, a combined interrupt
// and capture of the first channel (and cause) to fault while irq was idle.
module fsm_watchdog_monitor
    import fsm_watchdog_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int STATE_W    = 3,
    parameter int NUM_STATES = 6,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             enable,
    input  logic [CNT_W-1:0]              timeout_val,
    input  logic [NUM_CH*STATE_W-1:0]     state_in,
    input  logic [NUM_CH-1:0]             clear,
    output logic [NUM_CH-1:0]             timeout_flag,
    output logic [NUM_CH-1:0]             illegal_flag,
    output logic                          irq,
    output logic [ch_idx_w(NUM_CH)-1:0]   first_ch,
    output logic                          first_cause
);

    localparam int LP_CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0]  w_trip;
    cause_e             w_trip_cause [NUM_CH];
    logic               w_any_trip;
    logic [LP_CH_W-1:0] w_sel_ch;
    cause_e             w_sel_cause;
    logic [LP_CH_W-1:0] r_first_ch;
    cause_e             r_first_cause;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        fsm_watchdog_chan #(
            .STATE_W    (STATE_W),
            .NUM_STATES (NUM_STATES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .i_enable       (enable[g]),
            .i_clear        (clear[g]),
            .i_timeout_val  (timeout_val),
            .i_state        (state_in[g*STATE_W +: STATE_W]),
            .o_timeout_flag (timeout_flag[g]),
            .o_illegal_flag (illegal_flag[g]),
            .o_trip         (w_trip[g]),
            .o_trip_cause   (w_trip_cause[g])
        );
    end

    assign irq         = (|timeout_flag) | (|illegal_flag);
    assign first_ch    = r_first_ch;
    assign first_cause = r_first_cause;

    // Priority encoder: scan high to low so the lowest tripping index wins.
    always_comb begin
        w_any_trip  = 1'b0;
        w_sel_ch    = '0;
        w_sel_cause = CAUSE_TIMEOUT;
        for (int n = NUM_CH - 1; n >= 0; n--) begin
            if (w_trip[n]) begin
                w_any_trip  = 1'b1;
                w_sel_ch    = LP_CH_W'(n);
                w_sel_cause = w_trip_cause[n];
            end else begin
                w_any_trip  = w_any_trip;
            end
        end
    end

    // First-fault capture: latch only while no flag is up, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_ch    <= '0;
            r_first_cause <= CAUSE_TIMEOUT;
        end else if (!irq && w_any_trip) begin
            r_first_ch    <= w_sel_ch;
            r_first_cause <= w_sel_cause;
        end else begin
            r_first_ch    <= r_first_ch;
            r_first_cause <= r_first_cause;
        end
    end

endmodule

// File: doc/fsm_watchdog_monitor.md
FSM_WATCHDOG_MONITOR -- requirements
Module: fsm_watchdog_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independently monitored FSM channels (1..32).
REQ-002 SHALL have parameter STATE_W, default 3: state encoding width per channel.
REQ-003 SHALL have parameter NUM_STATES, default 6: legal encodings are 0..NUM_STATES-1.
REQ-004 SHALL have parameter CNT_W, default 16: stall counter and timeout width.
REQ-005 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1: sample clock, all logic on posedge.
REQ-007 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-008 SHALL have port enable, input, NUM_CH: per-channel monitor enable.
REQ-009 SHALL have port timeout_val, input, CNT_W: shared stall limit in cycles; 0 disables the timeout check.
REQ-010 SHALL have port state_in, input, NUM_CH*STATE_W: channel n state at bits [n*STATE_W +: STATE_W].
REQ-011 SHALL have port clear, input, NUM_CH: per-channel sticky-flag clear.
REQ-012 SHALL have port timeout_flag, output, NUM_CH: channel stalled.
REQ-013 SHALL have port illegal_flag, output, NUM_CH: channel visited an illegal encoding.
REQ-014 SHALL have port irq, output, 1: OR of all timeout_flag and illegal_flag bits.
REQ-015 SHALL have port first_ch, output, $clog2(NUM_CH) (min 1): index of the first faulting channel.
REQ-016 SHALL have port first_cause, output, 1: cause of the first fault, 0 timeout, 1 illegal.

Function
REQ-017 Each channel SHALL run an FSM with states DISABLED, ARMED, TIMEOUT and ILLEGAL.
REQ-018 DISABLED->ARMED SHALL occur when enable[n]=1; on entry, state_q loads state_in and stall_cnt is set to 0.
REQ-019 In ARMED, stall_cnt SHALL reset to 0 when state_in!=state_q, and otherwise increment, saturating at all-ones; state_q SHALL track state_in every cycle.
REQ-020 ARMED->TIMEOUT SHALL occur when timeout_val!=0, state_in==state_q and stall_cnt==timeout_val-1; timeout_flag rises on the following cycle.
REQ-021 ARMED->ILLEGAL SHALL occur when state_in>=NUM_STATES; illegal_flag rises the following cycle.
REQ-022 If both trip conditions hold in one cycle, ILLEGAL SHALL win.
REQ-023 TIMEOUT and ILLEGAL SHALL be sticky, with the flag held and the counter frozen, until clear[n] or enable[n]=0.
REQ-024 clear[n] SHALL return the channel to ARMED (or DISABLED if enable[n]=0), with the flag low next cycle, the counter at 0 and state_q reloaded.
REQ-025 clear[n] SHALL have priority over a same-cycle trip condition on that channel, and the trip SHALL be discarded.
REQ-026 enable[n]=0 SHALL force DISABLED from any state, with flags low next cycle.
REQ-027 timeout_flag[n] and illegal_flag[n] SHALL be registered state decodes, with no combinational path from inputs.
REQ-028 irq SHALL be combinational OR of the registered flags, adding zero extra latency.
REQ-029 First-fault capture: when irq is 0 and any channel trips, first_ch and first_cause SHALL latch the lowest-index tripping channel and its cause.
REQ-030 first_ch and first_cause SHALL hold until irq returns to 0, and later trips SHALL not overwrite them.
REQ-031 A timeout_val change mid-count SHALL take effect on the next compare, without resetting the counter.
REQ-032 If the counter is already past the new limit, no trip SHALL occur until the next state change and re-count.

Reset
REQ-033 rst SHALL put all channels in DISABLED, set state_q and stall_cnt to 0, and drive all flags, irq, first_ch and first_cause to 0 on the next edge.
REQ-034 rst SHALL override enable, clear and all trip conditions, including mid-count or while tripped.

Structure
REQ-035 Package fsm_watchdog_pkg SHALL hold the chan_state_e enum (DISABLED, ARMED, TIMEOUT, ILLEGAL) and the cause_e enum (CAUSE_TIMEOUT=0, CAUSE_ILLEGAL=1).
REQ-036 Sub-module fsm_watchdog_chan SHALL implement one channel (FSM, counter, state_q) and be instantiated NUM_CH times via generate.
REQ-037 The top SHALL hold only the irq OR and the first-fault priority/capture logic.

Verification
REQ-038 Scenarios SHALL use NUM_CH=4, STATE_W=3, NUM_STATES=6, timeout_val=5.
REQ-039 Timeout: ch0 enabled with state_in held at 2 -> timeout_flag[0] rises exactly 6 cycles after enable, irq=1, first_ch=0, first_cause=0.
REQ-040 No false trip: ch1 state toggles 1,2,1,2 each 4 cycles for 100 cycles -> timeout_flag[1] never rises.
REQ-041 Illegal: ch2 state_in=7 for 1 cycle -> illegal_flag[2] next cycle, sticky after state returns to 0, first_cause=1.
REQ-042 Simultaneous trips: ch3 illegal and ch1 timeout in the same cycle -> first_ch=1; clearing ch1 only keeps irq=1 with first_ch still 1.
REQ-043 Clear priority: clear[0] asserted on the trip cycle -> no flag; ch0 re-arms and trips 5 stable cycles later.
REQ-044 Reset mid-operation: rst during a trip with stall_cnt=3 -> all outputs 0 next cycle, and after rst falls a full 5-cycle stall is required to trip.
